arb_mux_reg: RTL
================

Name: arb_mux_reg

Overview:
- Parametrised, registered successor to the datapath N-way select mux: N input channels of WIDTH bits, each with a valid/ready handshake, merged onto one registered output channel.
- Two compile-time modes:
  - Explicit select: a `sel` input picks the channel, as with the existing datapath muxes.
  - Round-robin: fair arbitration among valid channels.
- Sits between producers (e.g. pipe/score/sprite units) and a single consumer. It replaces ad-hoc combinational muxes wherever timing closure or backpressure is needed.

Parameters:
- WIDTH, 32: data width per channel.
- N, 6: number of input channels, legal range 2..16.
- MODE, 0: 0 = select-driven (MODE_SEL), 1 = round-robin (MODE_RR).
- SEL_W is a localparam, not overridable: clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready, combinational.
- sel  in  SEL_W  channel select; used only when MODE=0, ignored otherwise.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_src  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, rr pointer last=N-1 (so channel 0 has first priority).
- While rst=1, in_ready=0 for all channels.
- Reset mid-operation discards any held output word. No in_ready may pulse in the reset cycle.
- load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant selection, evaluated combinationally every cycle:
  - MODE_SEL: grant_vld = (sel < N) && in_valid[sel]; grant = sel. If sel >= N, there is no grant.
  - MODE_RR: search channels last+1, last+2, …, wrapping mod N; the first with in_valid=1 wins. grant_vld=0 if no channel is valid.
- in_ready[i] = !rst && load && grant_vld && (grant==i). At most one bit is high, i.e. in_ready is one-hot or zero.
- Transfer on channel i: in_valid[i] && in_ready[i] at the clock edge.
  - Next cycle: out_data = that channel's data, out_src = i, out_valid = 1.
  - MODE_RR only: last <= i. The pointer does not move without a transfer.
- If load=1 and grant_vld=0: out_valid <= 0; out_data and out_src hold their last values.
- If out_valid=1 and out_ready=0: out_data, out_src and out_valid are held stable; all in_ready=0.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle under continuous out_ready=1. Simultaneous output drain and input fill in the same cycle is required (no bubble).
- Fairness (MODE_RR): with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0 with no repeats. A channel waits at most N-1 grants.
- in_valid may drop without a transfer; the block does not latch requests.
- Unused in_data bits never propagate; out_data always equals a whole WIDTH-bit channel slice.

Decomposition:
- Shared package `arb_pkg`:
  - constants MODE_SEL=0, MODE_RR=1
  - function clog2 (shared by all parametrised blocks)
- Sub-module `rr_arbiter` (params N), used in MODE_RR only:
  - inputs clk, rst, req[N], advance
  - outputs grant (SEL_W), grant_vld
  - owns the pointer register; advance = transfer strobe
- MODE_SEL path: inline comparator plus indexing, no sub-module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0 throughout; out_valid=0, out_data=0, out_src=0 after reset.
- MODE_SEL, N=6: sel=3, in_valid=6'b001000, ch3 data=32'hDEADBEEF, out_ready=1 -> in_ready=6'b001000 the same cycle; next cycle out_data=DEADBEEF, out_src=3, out_valid=1. sel=7 -> in_ready=0 and out_valid drops.
- Backpressure: out_valid=1 with out_src=2, out_ready=0 for 4 cycles while ch1/ch4 valid -> out_data/out_src unchanged and in_ready=0 for all 4 cycles. out_ready=1 -> new word loads the next cycle with no bubble.
- MODE_RR fairness: all 6 valid, channel data = 100+i, out_ready=1 for 13 cycles -> out_src sequence 0,1,2,3,4,5,0,1,2,3,4,5,0 and out_data 100..105 repeating.
- MODE_RR skip/wrap: last=4, in_valid=6'b000011 -> grant ch0; next cycle (last=0) grant ch1. The pointer is unchanged on cycles with in_valid=0.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0; after release, the first RR grant goes to ch0 even if ch5 was granted last.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : arb_pkg
//  Description: Shared mode constants and the clog2 helper used by the
//               parametrised arbitration / mux blocks.
//  Revision   : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int MODE_SEL = 0;   // explicit select input picks the channel
   localparam int MODE_RR  = 1;   // round-robin among valid channels

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module     : rr_arbiter
//  Description: Round-robin arbiter with a registered "last granted" pointer.
//               The search starts one past the last winner and wraps mod N.
//               The pointer only moves on the advance (transfer) strobe.
//  Revision   : 1.0 - initial release
//  Ports      : clk       - system clock, rising edge
//               rst       - synchronous active-high reset (pointer -> N-1)
//               req       - per-channel request (N)
//               advance   - transfer strobe; commits grant into the pointer
//               grant     - winning channel index (SEL_W)
//               grant_vld - at least one request present
// ============================================================================
module rr_arbiter
   import arb_pkg::*;
#(
   parameter  int N     = 6,
   localparam int SEL_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [SEL_W-1:0] grant,
   output logic             grant_vld
);

   logic [SEL_W-1:0] last_q;
   logic [SEL_W-1:0] last_d;
   int               idx;

   // Walk from the farthest offset down to the nearest so the last hit
   // written is the closest requester after the pointer.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(last_q) + k) % N;
         if (req[idx]) begin
            grant     = SEL_W'(idx);
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (advance) last_d = grant;
   end

   // Reset to N-1 so channel 0 holds first priority.
   always_ff @(posedge clk) begin
      if (rst) last_q <= SEL_W'(N - 1);
      else     last_q <= last_d;
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module     : arb_mux_reg
//  Description: N-channel valid/ready mux merged onto one registered output.
//               MODE_SEL: channel chosen by sel; MODE_RR: round-robin.
//               The output register drains and refills in the same cycle.
//  Revision   : 1.0 - initial release
//  Ports      : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               in_data   - flattened channel data, ch i at [i*WIDTH +: WIDTH]
//               in_valid  - per-channel valid
//               in_ready  - per-channel ready (combinational, one-hot or 0)
//               sel       - channel select (MODE_SEL only)
//               out_data  - registered selected data
//               out_valid - registered output valid
//               out_ready - consumer ready
//               out_src   - channel index that supplied out_data
// ============================================================================
module arb_mux_reg
   import arb_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N     = 6,
   parameter  int MODE  = 0,
   localparam int SEL_W = clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_src
);

   // Padded to a power of two so any SEL_W-bit index is in range.
   localparam int PAD_N = 1 << SEL_W;

   logic [WIDTH-1:0] w_ch [PAD_N];
   logic [SEL_W-1:0] w_grant;
   logic             w_grant_vld;
   logic             w_load;
   logic             w_xfer;

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_src_q,   out_src_d;
   logic             out_valid_q, out_valid_d;

   for (genvar i = 0; i < PAD_N; i++) begin : g_unpack
      if (i < N) begin : g_real
         assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
      end else begin : g_pad
         assign w_ch[i] = '0;
      end
   end

   if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.N(N)) u_rr_arbiter (
         .clk       (clk),
         .rst       (rst),
         .req       (in_valid),
         .advance   (w_xfer),
         .grant     (w_grant),
         .grant_vld (w_grant_vld)
      );
   end else begin : g_sel
      localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);
      logic [PAD_N-1:0] w_valid_pad;
      assign w_valid_pad = PAD_N'(in_valid);
      assign w_grant     = sel;
      assign w_grant_vld = ({1'b0, sel} < N_EXT) && w_valid_pad[sel];
   end

   // Register may take a word when empty or being drained this cycle.
   assign w_load   = !out_valid_q || out_ready;
   assign w_xfer   = !rst && w_load && w_grant_vld;
   assign in_ready = w_xfer ? (N'(1) << w_grant) : '0;

   always_comb begin
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      if (w_load) begin
         out_valid_d = w_xfer;
         if (w_xfer) begin
            out_data_d = w_ch[w_grant];
            out_src_d  = w_grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule : arb_mux_reg
`default_nettype wire
